// File: rtl/msg_arbiter_pkg.sv
// Shared types and constants for the two-input message arbiter.
// Holds FSM encoding, input indices and message/event type codes.
package msg_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int unsigned IN0 = 0;
    localparam int unsigned IN1 = 1;

    localparam logic [7:0] MSG_TYPE_EVENT = 8'h01;
    localparam logic [7:0] MSG_TYPE_USER  = 8'h02;

    localparam logic [7:0] EVT_TYPE_NONE  = 8'h00;
    localparam logic [7:0] EVT_TYPE_ERROR = 8'h01;
    localparam logic [7:0] EVT_TYPE_INFO  = 8'h02;

endpackage

// File: rtl/msg_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins, a tie goes to
// the input that was not granted last. Purely combinational.
module rr_arbiter2
    import msg_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i[IN0] && req_i[IN1]) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/msg_arbiter.sv
// Merges two single-beat AXI-Stream sources into one registered
// output, alternating between sources when both are waiting.
module msg_arbiter
    import msg_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DATA_WIDTH-1:0]  AXIS_IN0_TDATA,
    input  logic                   AXIS_IN0_TVALID,
    output logic                   AXIS_IN0_TREADY,
    input  logic [DATA_WIDTH-1:0]  AXIS_IN1_TDATA,
    input  logic                   AXIS_IN1_TVALID,
    output logic                   AXIS_IN1_TREADY,
    output logic [DATA_WIDTH-1:0]  AXIS_OUT_TDATA,
    output logic                   AXIS_OUT_TVALID,
    input  logic                   AXIS_OUT_TREADY,
    output logic [COUNT_WIDTH-1:0] count0,
    output logic [COUNT_WIDTH-1:0] count1
);

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   src_q, src_d;
    logic                   last_q, last_d;
    logic [COUNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [COUNT_WIDTH-1:0] cnt1_q, cnt1_d;
    logic [1:0]             req;
    logic [1:0]             gnt;

    // Requests are masked in reset so no grant fires before release.
    assign req = {AXIS_IN1_TVALID, AXIS_IN0_TVALID}
               & {2{resetn && (state_q == IDLE)}};

    rr_arbiter2 u_arb (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign AXIS_IN0_TREADY = gnt[IN0];
    assign AXIS_IN1_TREADY = gnt[IN1];
    assign AXIS_OUT_TDATA  = data_q;
    assign AXIS_OUT_TVALID = (state_q == SEND);
    assign count0          = cnt0_q;
    assign count1          = cnt1_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    data_d  = gnt[IN1] ? AXIS_IN1_TDATA
                                       : AXIS_IN0_TDATA;
                    src_d   = gnt[IN1];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (AXIS_OUT_TREADY) begin
                    state_d = IDLE;
                    last_d  = src_q;
                    if (src_q) begin
                        cnt1_d = cnt1_q + COUNT_WIDTH'(1);
                    end else begin
                        cnt0_d = cnt0_q + COUNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_msg_arbiter.sv
// Directed scoreboard bench for msg_arbiter: expected messages are
// queued with the stimulus and popped at each output handshake.
module tb_msg_arbiter;

    localparam int DW = 256;
    localparam int CW = 4;

    typedef struct {
        logic          src;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] d0, d1, od;
    logic          v0, v1, r0, r1, ov, ordy;
    logic [CW-1:0] c0, c1;

    exp_t          expq[$];
    logic [DW-1:0] pend0[$];
    logic [DW-1:0] pend1[$];
    logic [CW-1:0] mc0, mc1;
    logic          hs0, hs1;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    msg_arbiter #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .AXIS_IN0_TDATA  (d0),
        .AXIS_IN0_TVALID (v0),
        .AXIS_IN0_TREADY (r0),
        .AXIS_IN1_TDATA  (d1),
        .AXIS_IN1_TVALID (v1),
        .AXIS_IN1_TREADY (r1),
        .AXIS_OUT_TDATA  (od),
        .AXIS_OUT_TVALID (ov),
        .AXIS_OUT_TREADY (ordy),
        .count0          (c0),
        .count1          (c1)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        v0 = (pend0.size() > 0);
        d0 = v0 ? pend0[0] : '0;
        v1 = (pend1.size() > 0);
        d1 = v1 ? pend1[0] : '0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic tick();
        exp_t e;
        logic hso;
        #1;
        hs0 = v0 && r0;
        hs1 = v1 && r1;
        hso = ov && ordy;
        if (hso) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed=%0h expected=none", od);
            end
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("out_data", od, e.data);
                if (e.src) mc1++;
                else       mc0++;
            end
        end
        @(negedge clk);
        if (hs0) void'(pend0.pop_front());
        if (hs1) void'(pend1.pop_front());
        apply();
        if (hso) begin
            chk("count0", DW'(c0), DW'(mc0));
            chk("count1", DW'(c1), DW'(mc1));
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 ||
                expq.size() > 0 || ov) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        assert (n < bound) else begin
            errors++;
            $error("FAIL drain_timeout observed=%0d expected<%0d", n, bound);
        end
    endtask

    task automatic wait_ov(input int bound);
        int n = 0;
        while (!ov && n < bound) begin
            tick();
            n++;
        end
        chk("wait_out_valid", DW'(ov), DW'(1));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        pend0.delete();
        pend1.delete();
        expq.delete();
        mc0  = '0;
        mc1  = '0;
        ordy = 1'b0;
        apply();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] ma, mb, mc, md;
        int n;

        resetn = 1'b0;
        ordy   = 1'b1;
        mc0    = '0;
        mc1    = '0;
        hs0    = 1'b0;
        hs1    = 1'b0;

        // reset state with both sources requesting
        pend0.push_back(DW'(1));
        pend1.push_back(DW'(2));
        apply();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_tready0", DW'(r0), DW'(0));
        chk("rst_tready1", DW'(r1), DW'(0));
        chk("rst_tvalid", DW'(ov), DW'(0));
        chk("rst_tdata", od, '0);
        chk("rst_count0", DW'(c0), DW'(0));
        chk("rst_count1", DW'(c1), DW'(0));

        // single message, one-cycle latency
        do_reset();
        ma = {32{8'h01}};
        pend0.push_back(ma);
        expq.push_back('{1'b0, ma});
        ordy = 1'b1;
        apply();
        n = 0;
        hs0 = 1'b0;
        while (!hs0 && n < 5) begin
            tick();
            n++;
        end
        chk("t1_in_handshake", DW'(hs0), DW'(1));
        chk("t1_latency_valid", DW'(ov), DW'(1));
        chk("t1_data", od, ma);
        drain(10);
        chk("t1_count0", DW'(c0), DW'(1));

        // both continuously valid: strict alternation from input 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pend0.push_back(DW'(32'h100 + i));
            pend1.push_back(DW'(32'h200 + i));
            expq.push_back('{1'b0, DW'(32'h100 + i)});
            expq.push_back('{1'b1, DW'(32'h200 + i)});
        end
        ordy = 1'b1;
        apply();
        drain(40);
        chk("t2_count0", DW'(c0), DW'(4));
        chk("t2_count1", DW'(c1), DW'(4));

        // output stall: data stable, no input accepted
        do_reset();
        ma = {8{32'hA5A5_0001}};
        mb = {8{32'hA5A5_0002}};
        mc = {8{32'hC3C3_0001}};
        pend0.push_back(ma);
        pend0.push_back(mb);
        pend1.push_back(mc);
        expq.push_back('{1'b0, ma});
        expq.push_back('{1'b1, mc});
        expq.push_back('{1'b0, mb});
        apply();
        wait_ov(5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_data", od, ma);
            chk("t3_hold_valid", DW'(ov), DW'(1));
            chk("t3_tready0_low", DW'(r0), DW'(0));
            chk("t3_tready1_low", DW'(r1), DW'(0));
        end
        ordy = 1'b1;
        drain(20);
        chk("t3_count0", DW'(c0), DW'(2));
        chk("t3_count1", DW'(c1), DW'(1));

        // reset in SEND discards the held message
        do_reset();
        md = {8{32'hDEAD_BEEF}};
        pend0.push_back(md);
        apply();
        wait_ov(5);
        #2;
        resetn = 1'b0;
        mc0 = '0;
        mc1 = '0;
        #1;
        chk("t4_async_valid", DW'(ov), DW'(0));
        chk("t4_async_data", od, '0);
        chk("t4_count0", DW'(c0), DW'(0));
        @(negedge clk);
        resetn = 1'b1;
        ordy   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_no_resend", DW'(ov), DW'(0));
        chk("t4_count0_after", DW'(c0), DW'(0));

        // 4-bit counter wrap on input 1
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            pend1.push_back(DW'(32'h300 + i));
            expq.push_back('{1'b1, DW'(32'h300 + i)});
        end
        ordy = 1'b1;
        apply();
        drain(100);
        chk("t5_count1_wrap", DW'(c1), DW'(1));
        chk("t5_count0", DW'(c0), DW'(0));

        // brief IN1 valid while in SEND is ignored
        do_reset();
        ma = {8{32'hE000_0001}};
        pend0.push_back(ma);
        expq.push_back('{1'b0, ma});
        apply();
        wait_ov(5);
        pend1.push_back({8{32'hF000_0001}});
        apply();
        tick();
        chk("t6_no_accept", DW'(hs1), DW'(0));
        pend1.delete();
        apply();
        tick();
        tick();
        ordy = 1'b1;
        drain(10);
        chk("t6_count1", DW'(c1), DW'(0));
        chk("t6_count0", DW'(c0), DW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
